// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the combination lock controller.
//   state_e  : controller FSM states
//   DIGITS   : number of digits in a combination
//   DIGIT_W  : bits per digit (one switch nibble)
//   ENTRY_W  : width of the collected entry / combination
// -----------------------------------------------------------------------------
package lock_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CHECK   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_e;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int ENTRY_W = DIGITS * DIGIT_W;

    // Larger of two cycle counts; sizes the single shared timer.
    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw, bouncing pushbutton into the clk domain, accepts a new
// level only after it has been stable for DEBOUNCE_CYCLES cycles, and emits a
// one-cycle pulse on each accepted rising edge.
//   clk    in  : clock
//   rst    in  : synchronous active-high reset
//   btn    in  : raw asynchronous button
//   level  out : debounced button level
//   rise_p out : one-cycle pulse, three cycles after the level is accepted
//                counting from the raw edge: raw edge at t -> pulse at t+3+D
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise_p
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter runs only while the synchronised input disagrees with the
    // accepted level; any agreement (a glitch ending) restarts it from zero.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            rise_q      <= rise_d;
            cnt_q       <= cnt_d;
        end
    end

    assign level  = level_q;
    assign rise_p = rise_q;

endmodule

// File: rtl/lock_ctrl.sv
// -----------------------------------------------------------------------------
// lock_ctrl
// Combination lock controller. Debounces the enter/clear buttons, collects a
// four-digit code from the switches, compares it with CODE and opens the lock
// for OPEN_CYCLES cycles on a match. MAX_FAIL consecutive wrong codes lock
// all inputs out for LOCKOUT_CYCLES cycles.
//   clk        in  : board clock
//   rst        in  : synchronous active-high reset
//   sw         in  : digit value on the switches (sampled on an enter pulse)
//   btn_enter  in  : raw enter button, captures sw as the next digit
//   btn_clear  in  : raw clear button, discards the entry or closes early
//   open       out : high while in OPEN
//   locked_out out : high while in LOCKOUT
//   digit_cnt  out : digits captured so far (0..4)
//   fail_cnt   out : consecutive failures (0..MAX_FAIL)
// -----------------------------------------------------------------------------
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                   DEBOUNCE_CYCLES = 1_000_000,
    parameter int                   OPEN_CYCLES     = 500_000_000,
    parameter int                   LOCKOUT_CYCLES  = 1_000_000_000,
    parameter int                   MAX_FAIL        = 3,
    parameter logic [ENTRY_W-1:0]   CODE            = 16'h0846
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   sw,
    input  logic         btn_enter,
    input  logic         btn_clear,
    output logic         open,
    output logic         locked_out,
    output logic [2:0]   digit_cnt,
    output logic [1:0]   fail_cnt
);

    localparam int TMR_W = $clog2(max_cycles(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(1);
    localparam logic [2:0]       LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [1:0]       FAIL_LIMIT = 2'(MAX_FAIL);

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = enter, index 1 = clear
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_rise;
    // Debounced levels are not needed by the FSM, which acts on edges only.
    logic [1:0] btn_level_unused;

    assign btn_raw = {btn_clear, btn_enter};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn    (btn_raw[gi]),
            .level  (btn_level_unused[gi]),
            .rise_p (btn_rise[gi])
        );
    end

    logic enter_p, clear_p;
    assign enter_p = btn_rise[0];
    assign clear_p = btn_rise[1];

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic [2:0]         digit_q, digit_d;
    logic [1:0]         fail_q,  fail_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         fail_inc;

    assign fail_inc = fail_q + 2'd1;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        digit_d = digit_q;
        fail_d  = fail_q;
        timer_d = timer_q;

        unique case (state_q)
            ENTRY: begin
                // Clear has priority over a simultaneous enter.
                if (clear_p) begin
                    digit_d = '0;
                    entry_d = '0;
                end else if (enter_p) begin
                    // sw has long settled by the time a debounced pulse
                    // arrives, so it is sampled directly without syncing.
                    entry_d = {entry_q[ENTRY_W-DIGIT_W-1:0], sw};
                    digit_d = digit_q + 3'd1;
                    if (digit_q == LAST_DIGIT) begin
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                entry_d = '0;
                digit_d = '0;
                if (entry_q == CODE) begin
                    state_d = OPEN;
                    fail_d  = '0;
                    timer_d = OPEN_LOAD;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_d = LOCKOUT;
                        timer_d = LOCK_LOAD;
                    end else begin
                        state_d = ENTRY;
                    end
                end
            end

            OPEN: begin
                // Timer counts load..1, giving exactly OPEN_CYCLES in OPEN.
                if (clear_p || timer_q == TMR_LAST) begin
                    state_d = ENTRY;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            LOCKOUT: begin
                if (timer_q == TMR_LAST) begin
                    state_d = ENTRY;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTRY;
            entry_q <= '0;
            digit_q <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            digit_q <= digit_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Outputs decoded from registered state only.
    assign open       = (state_q == OPEN);
    assign locked_out = (state_q == LOCKOUT);
    assign digit_cnt  = digit_q;
    assign fail_cnt   = fail_q;

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Keypad-style combination lock controller that produces the `open` qualifier consumed by the seven-segment/LED scan driver downstream. Debounces raw pushbuttons, collects a four-digit code from the digit switches, compares it against a parameterised combination, and holds `open` high for a fixed window on a match. Repeated failures trigger a timed lockout. All logic runs on the board clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); minimum 2.
- `OPEN_CYCLES`, 500_000_000: cycles `open` stays high after a correct code.
- `LOCKOUT_CYCLES`, 1_000_000_000: cycles inputs are ignored after `MAX_FAIL` consecutive failures.
- `MAX_FAIL`, 3: consecutive wrong codes that trigger lockout; range 1..3.
- `CODE`, 16'h0846: combination, one nibble per digit, first-entered digit in bits [15:12].

Ports:
- `clk` in 1: board clock.
- `rst` in 1: synchronous, active-high reset.
- `sw` in 4: digit value presented on the switches; asynchronous, sampled only on an enter pulse.
- `btn_enter` in 1: raw, bouncing, asynchronous pushbutton; latches `sw` as the next digit.
- `btn_clear` in 1: raw, bouncing, asynchronous pushbutton; discards the entry or closes early.
- `open` out 1: high exactly while the FSM is in OPEN.
- `locked_out` out 1: high exactly while the FSM is in LOCKOUT.
- `digit_cnt` out 3: number of digits captured so far, 0..4.
- `fail_cnt` out 2: consecutive failures, 0..MAX_FAIL.

## Operation
- Per button: a 2-flop synchroniser, then a counter that increments while the synchronised value differs from the accepted level and clears when they match. When the count reaches `DEBOUNCE_CYCLES-1` and the values still differ, the level flips. A registered rising edge of the level gives a one-cycle pulse (`enter_p`, `clear_p`). Falling edges produce no pulse.
- FSM states: ENTRY, CHECK, OPEN, LOCKOUT.
- ENTRY:
  - `clear_p` sets `digit_cnt` to 0.
  - Otherwise `enter_p` shifts `sw` into a 16-bit entry register from the low nibble and increments `digit_cnt`.
  - When the capture makes `digit_cnt` 4, the next state is CHECK.
- CHECK (one cycle):
  - If entry == `CODE`, go to OPEN and clear `fail_cnt`.
  - Otherwise increment `fail_cnt`. If the new value == `MAX_FAIL`, go to LOCKOUT; else go to ENTRY.
  - Both branches clear `digit_cnt` and the entry register.
- OPEN: a timer runs `OPEN_CYCLES` cycles, then the FSM returns to ENTRY. `clear_p` returns to ENTRY immediately. `enter_p` is ignored.
- LOCKOUT: all pulses are ignored. After `LOCKOUT_CYCLES` cycles the FSM goes to ENTRY with `fail_cnt` = 0.
- Simultaneous `enter_p` and `clear_p`: clear wins and no digit is captured.
- `sw` values A–F are accepted as-is with no validation.
- Timer widths use `$clog2` of the parameter. Timers load on state entry and count down to 1.

## Timing
- Reset values:
  - `open`, `locked_out` = 0; `digit_cnt`, `fail_cnt` = 0; state = ENTRY.
  - Entry register, timers and debounce counters = 0; debounced levels = 0.
- `rst` mid-operation returns everything to reset values on the next edge, including aborting OPEN or LOCKOUT.
- Button latency: a raw edge at cycle t, held stable, produces a pulse in cycle t+3+DEBOUNCE_CYCLES. Any glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- When the 4th `enter_p` occurs in cycle p: CHECK is in p+1, and `open` or `locked_out` goes high in p+2.
- `open` stays high for exactly `OPEN_CYCLES` cycles. `locked_out` stays high for exactly `LOCKOUT_CYCLES` cycles.
- A `clear_p` in OPEN at cycle c drops `open` at c+1.
- All outputs are registered or decoded directly from registered state, so they are glitch-free for the downstream scan driver.

## Structure
- Package `lock_pkg`: state enum (ENTRY, CHECK, OPEN, LOCKOUT) and the `DIGITS = 4` constant.
- Sub-module `btn_debounce`, parameterised by `DEBOUNCE_CYCLES`, outputs `level` and `rise_p`. It is instantiated twice.
- The top level holds the FSM, entry shift register, comparator, `fail_cnt` and a single shared down-counter timer.

## Test plan
Run with `DEBOUNCE_CYCLES=4`, `OPEN_CYCLES=20`, `LOCKOUT_CYCLES=30`.
- Enter 0,8,4,6 (clean presses) -> `open`=1 two cycles after the 4th pulse, for exactly 20 cycles; `fail_cnt` stays 0.
- Bounce `btn_enter` with 3-cycle glitches, then hold it 10 cycles -> exactly one pulse, exactly 7 cycles after the stable edge; `digit_cnt` goes 0→1.
- Three wrong codes (1,1,1,1) -> `fail_cnt` 1, 2, then `locked_out`=1 for 30 cycles; presses during lockout leave `digit_cnt`=0; afterwards `fail_cnt`=0.
- Enter 0,8, then clear, then 0,8,4,6 -> `digit_cnt` 2→0, then open; enter and clear pulses in the same cycle -> no capture.
- Clear during OPEN at cycle c -> `open`=0 at c+1; assert `rst` mid-LOCKOUT -> all outputs 0 on the next edge.
- One wrong code, then the correct code -> `fail_cnt` 1→0 on open.
